// File: rtl/mem_lsu.sv
// Memory stage load/store unit: IDLE/ACCESS/DONE handshake with the data bus,
// big-endian byte lanes, misalignment and bus-timeout reporting.
module mem_lsu #(
   parameter int unsigned WAIT_MAX = 16,
   parameter logic [7:0]  OP_LB    = 8'hE0,
   parameter logic [7:0]  OP_LH    = 8'hE1,
   parameter logic [7:0]  OP_LW    = 8'hE3,
   parameter logic [7:0]  OP_LBU   = 8'hE4,
   parameter logic [7:0]  OP_LHU   = 8'hE5,
   parameter logic [7:0]  OP_SB    = 8'hE8,
   parameter logic [7:0]  OP_SH    = 8'hE9,
   parameter logic [7:0]  OP_SW    = 8'hEB
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  mem_wd,
   input  logic        mem_wreg,
   input  logic [31:0] mem_wdata,
   input  logic [31:0] mem_hi,
   input  logic [31:0] mem_lo,
   input  logic        mem_we,
   input  logic [31:0] mem_flags,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_reg2,
   input  logic [7:0]  mem_aluop,
   output logic [4:0]  wb_wd,
   output logic        wb_wreg,
   output logic [31:0] wb_wdata,
   output logic [31:0] wb_hi,
   output logic [31:0] wb_lo,
   output logic        wb_we,
   output logic [31:0] wb_flags,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [3:0]  dbus_sel,
   output logic [31:0] dbus_wdata,
   input  logic [31:0] dbus_rdata,
   input  logic        dbus_ack,
   output logic        stallreq,
   output logic        misalign_exc,
   output logic        bus_err
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state, state_next;
   logic [7:0]  cnt;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        bus_err_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  sel_q;
   logic        we_q;
   logic [7:0]  op_q;
   logic [1:0]  off_q;

   logic        is_load, is_store, is_mem, is_half, is_word;
   logic        misaligned, start, timeout;
   logic [3:0]  sel_c;
   logic [31:0] wdata_c;
   logic [31:0] ld_data;

   always_comb begin
      is_load    = (mem_aluop == OP_LB) || (mem_aluop == OP_LH) || (mem_aluop == OP_LW) ||
                   (mem_aluop == OP_LBU) || (mem_aluop == OP_LHU);
      is_store   = (mem_aluop == OP_SB) || (mem_aluop == OP_SH) || (mem_aluop == OP_SW);
      is_mem     = is_load || is_store;
      is_half    = (mem_aluop == OP_LH) || (mem_aluop == OP_LHU) || (mem_aluop == OP_SH);
      is_word    = (mem_aluop == OP_LW) || (mem_aluop == OP_SW);
      misaligned = is_mem && ((is_half && mem_addr[0]) || (is_word && (mem_addr[1:0] != 2'b00)));
      start      = is_mem && !misaligned;
      timeout    = (state == ACCESS) && !dbus_ack && (cnt == 8'(WAIT_MAX - 1));
   end

   // Big-endian lanes: byte offset 0 is the most significant byte.
   always_comb begin
      sel_c   = '0;
      wdata_c = '0;
      if (is_word) begin
         sel_c = 4'b1111;
      end else if (is_half) begin
         sel_c = mem_addr[1] ? 4'b0011 : 4'b1100;
      end else begin
         sel_c = 4'b1000 >> mem_addr[1:0];
      end
      if (mem_aluop == OP_SB) begin
         wdata_c = {4{mem_reg2[7:0]}};
      end else if (mem_aluop == OP_SH) begin
         wdata_c = {2{mem_reg2[15:0]}};
      end else if (mem_aluop == OP_SW) begin
         wdata_c = mem_reg2;
      end
   end

   always_comb begin
      logic [7:0]  byte_v;
      logic [15:0] half_v;
      case (off_q)
         2'd0:    byte_v = rdata_q[31:24];
         2'd1:    byte_v = rdata_q[23:16];
         2'd2:    byte_v = rdata_q[15:8];
         default: byte_v = rdata_q[7:0];
      endcase
      half_v = off_q[1] ? rdata_q[15:0] : rdata_q[31:16];
      if (op_q == OP_LB) begin
         ld_data = {{24{byte_v[7]}}, byte_v};
      end else if (op_q == OP_LBU) begin
         ld_data = {24'd0, byte_v};
      end else if (op_q == OP_LH) begin
         ld_data = {{16{half_v[15]}}, half_v};
      end else if (op_q == OP_LHU) begin
         ld_data = {16'd0, half_v};
      end else begin
         ld_data = rdata_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         bus_err_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         sel_q     <= '0;
         we_q      <= 1'b0;
         op_q      <= '0;
         off_q     <= '0;
      end else begin
         state     <= state_next;
         bus_err_q <= timeout;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (start) begin
                  addr_q  <= {mem_addr[31:2], 2'b00};
                  wdata_q <= wdata_c;
                  sel_q   <= sel_c;
                  we_q    <= is_store;
                  op_q    <= mem_aluop;
                  off_q   <= mem_addr[1:0];
               end
            end
            ACCESS: begin
               if (dbus_ack) begin
                  rdata_q <= dbus_rdata;
                  cnt     <= '0;
               end else if (timeout) begin
                  err_q <= 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: begin
               err_q <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = ACCESS;
         ACCESS:  if (dbus_ack || timeout) state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are forced low while reset is held, independent of the clock.
   always_comb begin
      wb_wd        = '0;
      wb_wreg      = 1'b0;
      wb_wdata     = '0;
      wb_hi        = '0;
      wb_lo        = '0;
      wb_we        = 1'b0;
      wb_flags     = '0;
      dbus_req     = 1'b0;
      dbus_we      = 1'b0;
      dbus_addr    = '0;
      dbus_sel     = '0;
      dbus_wdata   = '0;
      stallreq     = 1'b0;
      misalign_exc = 1'b0;
      bus_err      = 1'b0;
      if (rst) begin
         wb_wd    = mem_wd;
         wb_wreg  = mem_wreg;
         wb_wdata = mem_wdata;
         wb_hi    = mem_hi;
         wb_lo    = mem_lo;
         wb_we    = mem_we;
         wb_flags = mem_flags;
         bus_err  = bus_err_q;
         case (state)
            IDLE: begin
               if (misaligned) begin
                  misalign_exc = 1'b1;
                  wb_wreg      = 1'b0;
               end else if (start) begin
                  stallreq = 1'b1;
                  wb_wreg  = 1'b0;
                  wb_we    = 1'b0;
               end
            end
            ACCESS: begin
               stallreq   = 1'b1;
               wb_wreg    = 1'b0;
               wb_we      = 1'b0;
               dbus_req   = 1'b1;
               dbus_we    = we_q;
               dbus_addr  = addr_q;
               dbus_sel   = sel_q;
               dbus_wdata = wdata_q;
            end
            default: begin
               if (!we_q) wb_wdata = ld_data;
               if (err_q) wb_wreg = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed-vector bench for mem_lsu: pass-through, load/store lanes,
// misalignment, timeout, ack-vs-timeout boundary and asynchronous reset.
module tb_mem_lsu;

   localparam logic [7:0] ALU = 8'h21;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  mem_wd = '0;
   logic        mem_wreg = 1'b0;
   logic [31:0] mem_wdata = '0, mem_hi = '0, mem_lo = '0, mem_flags = '0;
   logic        mem_we = 1'b0;
   logic [31:0] mem_addr = '0, mem_reg2 = '0;
   logic [7:0]  mem_aluop = ALU;
   logic [4:0]  wb_wd;
   logic        wb_wreg, wb_we;
   logic [31:0] wb_wdata, wb_hi, wb_lo, wb_flags;
   logic        dbus_req, dbus_we;
   logic [31:0] dbus_addr, dbus_wdata;
   logic [3:0]  dbus_sel;
   logic [31:0] dbus_rdata = '0;
   logic        dbus_ack = 1'b0;
   logic        stallreq, misalign_exc, bus_err;

   int checks = 0;
   int errors = 0;

   mem_lsu #(.WAIT_MAX(16)) dut (
      .clk(clk), .rst(rst),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_we(mem_we), .mem_flags(mem_flags),
      .mem_addr(mem_addr), .mem_reg2(mem_reg2), .mem_aluop(mem_aluop),
      .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .wb_hi(wb_hi),
      .wb_lo(wb_lo), .wb_we(wb_we), .wb_flags(wb_flags),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
      .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
      .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
      .stallreq(stallreq), .misalign_exc(misalign_exc), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic alu_op(input string tag, input logic [31:0] data);
      @(negedge clk);
      mem_aluop = ALU; mem_wdata = data; mem_wreg = 1'b1; mem_wd = 5'd7;
      mem_hi = 32'h0000_00AA; mem_lo = 32'h0000_00BB; mem_we = 1'b1; mem_flags = 32'h5;
      #1;
      check({tag, "_wdata"}, wb_wdata, data);
      check({tag, "_wreg"}, wb_wreg, 1'b1);
      check({tag, "_wd"}, wb_wd, 5'd7);
      check({tag, "_hi"}, wb_hi, 32'h0000_00AA);
      check({tag, "_stall"}, stallreq, 1'b0);
      check({tag, "_req"}, dbus_req, 1'b0);
   endtask

   // One-cycle-ack load; expected lanes and result are hand-computed by the caller.
   task automatic do_load(input string tag, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [3:0] sel, input logic [31:0] exp);
      @(negedge clk);
      mem_aluop = op; mem_addr = addr; mem_wreg = 1'b1;
      #1 check({tag, "_stall0"}, stallreq, 1'b1);
      @(negedge clk); #1;
      check({tag, "_req"}, dbus_req, 1'b1);
      check({tag, "_addr"}, dbus_addr, {addr[31:2], 2'b00});
      check({tag, "_sel"}, dbus_sel, sel);
      check({tag, "_we"}, dbus_we, 1'b0);
      dbus_ack = 1'b1; dbus_rdata = rdata;
      @(negedge clk);
      dbus_ack = 1'b0;
      #1;
      check({tag, "_data"}, wb_wdata, exp);
      check({tag, "_done_stall"}, stallreq, 1'b0);
      @(negedge clk);
      mem_aluop = ALU;
   endtask

   task automatic do_store(input string tag, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] reg2, input logic [3:0] sel, input logic [31:0] exp);
      @(negedge clk);
      mem_aluop = op; mem_addr = addr; mem_reg2 = reg2; mem_wreg = 1'b0;
      @(negedge clk);
      mem_reg2 = 32'h0;
      #1;
      check({tag, "_we"}, dbus_we, 1'b1);
      check({tag, "_sel"}, dbus_sel, sel);
      check({tag, "_wdata"}, dbus_wdata, exp);
      check({tag, "_addr"}, dbus_addr, {addr[31:2], 2'b00});
      dbus_ack = 1'b1;
      @(negedge clk);
      dbus_ack = 1'b0;
      #1 check({tag, "_done_req"}, dbus_req, 1'b0);
      @(negedge clk);
      mem_aluop = ALU;
   endtask

   initial begin
      int n;
      logic seen;

      mem_wdata = 32'h1234_5678; mem_wreg = 1'b1;
      #2;
      check("rst_wdata", wb_wdata, 32'h0);
      check("rst_wreg", wb_wreg, 1'b0);
      check("rst_stall", stallreq, 1'b0);
      check("rst_req", dbus_req, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      alu_op("alu", 32'h1234_5678);

      // LB at offset 1 with ack in the third ACCESS cycle
      @(negedge clk);
      mem_aluop = 8'hE0; mem_addr = 32'h0000_0101; mem_wreg = 1'b1;
      n = 0;
      #1 if (stallreq) n++;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk); #1;
         if (stallreq) n++;
         if (k == 1) begin
            check("lb_addr", dbus_addr, 32'h0000_0100);
            check("lb_sel", dbus_sel, 4'b0100);
         end
         if (k == 3) begin
            dbus_ack = 1'b1; dbus_rdata = 32'h00F0_0000;
         end
      end
      @(negedge clk);
      dbus_ack = 1'b0;
      #1;
      check("lb_stall_cycles", n, 4);
      check("lb_data", wb_wdata, 32'hFFFF_FFF0);
      check("lb_wreg", wb_wreg, 1'b1);
      check("lb_done_stall", stallreq, 1'b0);
      @(negedge clk);
      mem_aluop = ALU;

      do_load("lbu3", 8'hE4, 32'h0000_0203, 32'h1122_3384, 4'b0001, 32'h0000_0084);
      do_load("lh0", 8'hE1, 32'h0000_0300, 32'h8001_0000, 4'b1100, 32'hFFFF_8001);
      do_load("lhu2", 8'hE5, 32'h0000_0302, 32'h1234_8001, 4'b0011, 32'h0000_8001);
      do_load("lw", 8'hE3, 32'h0000_0404, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

      do_store("sh", 8'hE9, 32'h0000_0002, 32'hAAAA_BEEF, 4'b0011, 32'hBEEF_BEEF);
      do_store("sb", 8'hE8, 32'h0000_0013, 32'h0000_125A, 4'b0001, 32'h5A5A_5A5A);
      do_store("sw", 8'hEB, 32'h0000_0020, 32'h0102_0304, 4'b1111, 32'h0102_0304);

      // misaligned word load
      @(negedge clk);
      mem_aluop = 8'hE3; mem_addr = 32'h0000_0006; mem_wreg = 1'b1;
      #1;
      check("mis_exc", misalign_exc, 1'b1);
      check("mis_wreg", wb_wreg, 1'b0);
      check("mis_stall", stallreq, 1'b0);
      check("mis_req", dbus_req, 1'b0);
      @(negedge clk); #1;
      check("mis_req2", dbus_req, 1'b0);
      mem_aluop = ALU;
      #1 check("mis_exc_clear", misalign_exc, 1'b0);

      // timeout: no ack at all
      @(negedge clk);
      mem_aluop = 8'hE3; mem_addr = 32'h0000_0010; mem_wreg = 1'b1;
      n = 0; seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         if (bus_err) begin
            seen = 1'b1;
            break;
         end
         if (dbus_req) n++;
      end
      check("to_seen", seen, 1'b1);
      check("to_cycles", n, 16);
      check("to_wreg", wb_wreg, 1'b0);
      check("to_req", dbus_req, 1'b0);
      check("to_stall", stallreq, 1'b0);
      @(negedge clk);
      mem_aluop = ALU;
      #1;
      check("to_err_pulse", bus_err, 1'b0);
      check("to_idle_wreg", wb_wreg, 1'b1);

      // ack in the same cycle the counter reaches the limit
      @(negedge clk);
      mem_aluop = 8'hE3; mem_addr = 32'h0000_0020; mem_wreg = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk); #1;
         if (k == 16) begin
            dbus_ack = 1'b1; dbus_rdata = 32'hCAFE_F00D;
         end
      end
      @(negedge clk);
      dbus_ack = 1'b0;
      #1;
      check("edge_err", bus_err, 1'b0);
      check("edge_wreg", wb_wreg, 1'b1);
      check("edge_data", wb_wdata, 32'hCAFE_F00D);
      @(negedge clk);
      mem_aluop = ALU;

      // stray ack in IDLE
      @(negedge clk);
      dbus_ack = 1'b1;
      #1 check("ack_idle_stall", stallreq, 1'b0);
      @(negedge clk);
      dbus_ack = 1'b0;
      #1 check("ack_idle_req", dbus_req, 1'b0);

      // reset asserted mid-ACCESS
      @(negedge clk);
      mem_aluop = 8'hE3; mem_addr = 32'h0000_0040;
      @(negedge clk); #1;
      check("rst_mid_req_before", dbus_req, 1'b1);
      rst = 1'b0;
      #1;
      check("rst_mid_req", dbus_req, 1'b0);
      check("rst_mid_stall", stallreq, 1'b0);
      @(negedge clk);
      mem_aluop = ALU;
      rst = 1'b1;
      alu_op("post_rst", 32'h0BAD_F00D);
      @(negedge clk); #1;
      check("post_rst_req", dbus_req, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter: WAIT_MAX, 16, maximum cycles in ACCESS without dbus_ack before timeout (range 1..255).
REQ-002 Parameter: OP_LB/OP_LH/OP_LW/OP_LBU/OP_LHU, 8'hE0/8'hE1/8'hE3/8'hE4/8'hE5, load aluop codes.
REQ-003 Parameter: OP_SB/OP_SH/OP_SW, 8'hE8/8'hE9/8'hEB, store aluop codes.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 mem_wd, mem_wreg, mem_wdata  in  5/1/32  destination register, write enable and ALU result from ex_mem.
REQ-007 mem_hi, mem_lo, mem_we, mem_flags  in  32/32/1/32  HI/LO values, HI/LO write enable and flags from ex_mem.
REQ-008 mem_addr, mem_reg2, mem_aluop  in  32/32/8  effective address, store data and operation code.
REQ-009 wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_we, wb_flags  out  5/1/32/32/32/1/32  results to mem_wb.
REQ-010 dbus_req, dbus_we  out  1/1  data-bus request and write strobe.
REQ-011 dbus_addr, dbus_sel, dbus_wdata  out  32/4/32  word-aligned address (addr[1:0]=0), byte lanes and write data.
REQ-012 dbus_rdata, dbus_ack  in  32/1  read data and one-cycle completion strobe.
REQ-013 stallreq  out  1  stall request to the pipeline controller; raising it asserts stall[4:0].
REQ-014 misalign_exc, bus_err  out  1/1  one-cycle error pulses.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-016 Non-memory aluop in IDLE: all wb_* outputs SHALL equal the corresponding mem_* inputs combinationally, with stallreq=0 (zero latency).
REQ-017 Aligned memory op in IDLE: stallreq=1 combinationally; next state ACCESS.
REQ-018 Alignment: halfword ops require addr[0]=0; word ops require addr[1:0]=0.
REQ-019 Misaligned op in IDLE: no bus access, misalign_exc=1 for that cycle, wb_wreg=0, stallreq=0, state stays IDLE.
REQ-020 ACCESS: dbus_req=1, and dbus_addr, dbus_we, dbus_sel and dbus_wdata SHALL be held stable until ack or timeout; stallreq=1.
REQ-021 Byte lanes are big-endian: byte offsets 0/1/2/3 map to sel 1000/0100/0010/0001 and data bits [31:24]/[23:16]/[15:8]/[7:0].
REQ-022 Halfword lanes: offset 0 maps to sel 1100 and bits [31:16]; offset 2 maps to sel 0011 and bits [15:0]. Word: sel 1111.
REQ-023 Stores SHALL replicate the low byte/halfword of mem_reg2 across all lanes and set dbus_we=1.
REQ-024 On dbus_ack in ACCESS: register dbus_rdata; next state DONE; the wait counter resets to 0.
REQ-025 Timeout: the counter counts ACCESS cycles; at count WAIT_MAX without ack, drop dbus_req, pulse bus_err, set the error flag, and enter DONE.
REQ-026 DONE: stallreq=0 and dbus_req=0; wb_* pass through, except for loads wb_wdata = extracted lane data (LB/LH sign-extended, LBU/LHU zero-extended, LW whole word).
REQ-027 DONE with error flag set: wb_wreg=0. DONE always returns to IDLE next cycle and clears the error flag.
REQ-028 dbus_ack arriving in IDLE or DONE SHALL be ignored.
REQ-029 Ack in the same cycle the counter reaches WAIT_MAX: the ack wins and no bus_err pulse occurs.

Reset
REQ-030 rst low SHALL immediately force: state IDLE, counter 0, captured data 0, error flag 0, and all outputs 0, including mid-ACCESS (dbus_req drops without waiting for ack).
REQ-031 After rst rises, the first operation SHALL begin from IDLE.

Verification
REQ-032 ALU op, mem_wdata=32'h1234_5678, wreg=1 -> same-cycle wb_wdata=32'h1234_5678, stallreq=0, dbus_req=0.
REQ-033 LB addr=32'h0000_0101, rdata=32'h00F0_0000, ack after 3 cycles -> dbus_addr=32'h0000_0100, sel=0100, stallreq high 4 cycles, DONE wb_wdata=32'hFFFF_FFF0.
REQ-034 SH addr=32'h0000_0002, reg2=32'hAAAA_BEEF -> dbus_we=1, sel=0011, dbus_wdata=32'hBEEF_BEEF.
REQ-035 LW addr=32'h0000_0006 -> misalign_exc pulse, wb_wreg=0, dbus_req never asserted.
REQ-036 LW with no ack, WAIT_MAX=16 -> bus_err after 16 ACCESS cycles, then DONE with wb_wreg=0, then IDLE.
REQ-037 rst asserted in ACCESS -> dbus_req and stallreq=0 immediately; after release, an ALU op passes through.
